// File: rtl/temporal_buffer_pkg.sv
// Shared widths, literal type and channel layout for the temporal buffer queue
// and the clause-table fetch stage that feeds it.
package temporal_buffer_pkg;

   localparam int LAW_DEFAULT = 11;

   // One clause-table literal: MSB is the polarity, the rest is the address.
   typedef logic [LAW_DEFAULT:0] literal_t;

   // Width of one entry: (NSAT-1) literals per channel, MCPV channels.
   function automatic int entry_width(input int nsat, input int mcpv, input int law);
      return (nsat - 1) * mcpv * (law + 1);
   endfunction

   // Index width, never narrower than one bit so ports stay legal.
   function automatic int index_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Width able to hold the values 0..depth.
   function automatic int occ_width(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

   // Bit offset of channel c inside an entry.
   function automatic int chan_offset(input int c, input int nsat, input int law);
      return c * (nsat - 1) * (law + 1);
   endfunction

endpackage

// File: rtl/tbq_bank.sv
// One bank: NSAT entries with a valid bit each, a write port, a combinational
// read port that reports a hit and returns zero on a miss, and a bulk clear.
module tbq_bank
   import temporal_buffer_pkg::*;
#(
   parameter int NSAT = 3,
   parameter int EW   = 480,
   parameter int IW   = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_index,
   input  logic [EW-1:0] wr_data,
   input  logic [IW-1:0] rd_index,
   output logic          rd_hit,
   output logic [EW-1:0] rd_data
);

   logic [EW-1:0]   mem_reg [NSAT];
   logic [NSAT-1:0] valid_reg;
   logic            rd_in_range;

   // Entry payload has no reset; the valid bits alone decide what is readable.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_reg[wr_index] <= wr_data;
      end
   end

   // Valid bits: cleared on reset/clear, set by a write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_reg <= '0;
      end else if (clear) begin
         valid_reg <= '0;
      end else if (wr_en) begin
         valid_reg[wr_index] <= 1'b1;
      end
   end

   assign rd_in_range = ({1'b0, rd_index} < (IW + 1)'(NSAT));

   // Read with hit: out-of-range or unwritten entries read as zero.
   always_comb begin
      rd_hit  = 1'b0;
      rd_data = '0;
      if (rd_in_range && valid_reg[rd_index]) begin
         rd_hit  = 1'b1;
         rd_data = mem_reg[rd_index];
      end
   end

endmodule

// File: rtl/temporal_buffer_queue.sv
// Multi-try temporal buffer: the writer fills the bank at wptr while the
// selector drains the oldest closed bank at rptr into a one-deep output register.
module temporal_buffer_queue
   import temporal_buffer_pkg::*;
#(
   parameter int NSAT  = 3,
   parameter int LAW   = 11,
   parameter int MCPV  = 20,
   parameter int DEPTH = 2,
   localparam int EW   = entry_width(NSAT, MCPV, LAW),
   localparam int IW   = index_width(NSAT),
   localparam int OW   = occ_width(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush_i,
   input  logic          wr_valid_i,
   output logic          wr_ready_o,
   input  logic [IW-1:0] wr_index_i,
   input  logic          wr_last_i,
   input  logic [EW-1:0] wr_literals_i,
   output logic          wr_err_o,
   input  logic          sel_valid_i,
   output logic          sel_ready_o,
   input  logic [IW-1:0] sel_index_i,
   output logic          rd_valid_o,
   input  logic          rd_ready_i,
   output logic          rd_hit_o,
   output logic [EW-1:0] rd_literals_o,
   output logic [OW-1:0] occupancy_o
);

   localparam int PW = index_width(DEPTH);
   localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

   logic [PW-1:0] wptr_reg, rptr_reg;
   logic [OW-1:0] cnt_reg;
   logic          rd_valid_reg, rd_hit_reg, wr_err_reg;
   logic [EW-1:0] rd_literals_reg;

   logic          wr_fire, sel_fire, wr_idx_ok, wr_close;
   logic [DEPTH-1:0] bank_hit;
   logic [EW-1:0]    bank_data [DEPTH];

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign wr_ready_o  = (cnt_reg < DEPTH_C);
   assign sel_ready_o = (cnt_reg != '0) && (!rd_valid_reg || rd_ready_i);
   assign occupancy_o = cnt_reg;

   // Flush suppresses both transfers so nothing lands in a bank being cleared.
   assign wr_fire   = wr_valid_i && wr_ready_o && !flush_i;
   assign sel_fire  = sel_valid_i && sel_ready_o && !flush_i;
   assign wr_idx_ok = ({1'b0, wr_index_i} < (IW + 1)'(NSAT));
   assign wr_close  = wr_fire && wr_last_i;

   // A write and a select in the same cycle always target different banks:
   // both firing needs 0 < cnt < DEPTH, which forces wptr != rptr.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_bank
         tbq_bank #(
            .NSAT (NSAT),
            .EW   (EW),
            .IW   (IW)
         ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .clear    (flush_i || (sel_fire && (rptr_reg == PW'(gi)))),
            .wr_en    (wr_fire && wr_idx_ok && (wptr_reg == PW'(gi))),
            .wr_index (wr_index_i),
            .wr_data  (wr_literals_i),
            .rd_index (sel_index_i),
            .rd_hit   (bank_hit[gi]),
            .rd_data  (bank_data[gi])
         );
      end
   endgenerate

   // Pointers, closed-bank count, error pulse and output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_reg        <= '0;
         rptr_reg        <= '0;
         cnt_reg         <= '0;
         wr_err_reg      <= 1'b0;
         rd_valid_reg    <= 1'b0;
         rd_hit_reg      <= 1'b0;
         rd_literals_reg <= '0;
      end else if (flush_i) begin
         wptr_reg        <= '0;
         rptr_reg        <= '0;
         cnt_reg         <= '0;
         wr_err_reg      <= 1'b0;
         rd_valid_reg    <= 1'b0;
         rd_hit_reg      <= 1'b0;
         rd_literals_reg <= '0;
      end else begin
         wr_err_reg <= wr_fire && !wr_idx_ok;
         if (wr_close) begin
            wptr_reg <= ptr_next(wptr_reg);
         end
         if (sel_fire) begin
            rptr_reg <= ptr_next(rptr_reg);
         end
         case ({wr_close, sel_fire})
            2'b10:   cnt_reg <= cnt_reg + OW'(1);
            2'b01:   cnt_reg <= cnt_reg - OW'(1);
            default: cnt_reg <= cnt_reg;
         endcase
         if (sel_fire) begin
            rd_valid_reg    <= 1'b1;
            rd_hit_reg      <= bank_hit[rptr_reg];
            rd_literals_reg <= bank_data[rptr_reg];
         end else if (rd_ready_i) begin
            rd_valid_reg <= 1'b0;
         end
      end
   end

   assign wr_err_o      = wr_err_reg;
   assign rd_valid_o    = rd_valid_reg;
   assign rd_hit_o      = rd_hit_reg;
   assign rd_literals_o = rd_literals_reg;

endmodule

// File: tb/tb_temporal_buffer_queue.sv
// Directed bench for temporal_buffer_queue with a queue-based reference model.
module tb_temporal_buffer_queue;
   import temporal_buffer_pkg::*;

   localparam int NSAT  = 3;
   localparam int LAW   = 11;
   localparam int MCPV  = 20;
   localparam int DEPTH = 2;
   localparam int EW    = entry_width(NSAT, MCPV, LAW);
   localparam int IW    = index_width(NSAT);
   localparam int OW    = occ_width(DEPTH);

   logic          clk, reset, flush_i;
   logic          wr_valid_i, wr_ready_o, wr_last_i, wr_err_o;
   logic [IW-1:0] wr_index_i, sel_index_i;
   logic [EW-1:0] wr_literals_i, rd_literals_o;
   logic          sel_valid_i, sel_ready_o, rd_valid_o, rd_ready_i, rd_hit_o;
   logic [OW-1:0] occupancy_o;

   int total = 0;
   int bad   = 0;

   // Reference model: closed banks as a FIFO, the open bank, the output register.
   logic [NSAT-1:0]    q_valid [$];
   logic [NSAT*EW-1:0] q_data  [$];
   logic [NSAT-1:0]    open_valid;
   logic [NSAT*EW-1:0] open_data;
   logic               m_rd_valid, m_hit, m_err;
   logic [EW-1:0]      m_lits;

   temporal_buffer_queue #(
      .NSAT(NSAT), .LAW(LAW), .MCPV(MCPV), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .flush_i(flush_i),
      .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_index_i(wr_index_i),
      .wr_last_i(wr_last_i), .wr_literals_i(wr_literals_i), .wr_err_o(wr_err_o),
      .sel_valid_i(sel_valid_i), .sel_ready_o(sel_ready_o), .sel_index_i(sel_index_i),
      .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_hit_o(rd_hit_o),
      .rd_literals_o(rd_literals_o), .occupancy_o(occupancy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [EW-1:0] pat(input logic [7:0] b);
      return {(EW / 8){b}};
   endfunction

   task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q_valid.delete();
      q_data.delete();
      open_valid = '0;
      open_data  = '0;
      m_rd_valid = 1'b0;
      m_hit      = 1'b0;
      m_err      = 1'b0;
      m_lits     = '0;
   endtask

   // Per-cycle compare of every meaningful DUT output against the model.
   task automatic check_all();
      chk("wr_ready", EW'(wr_ready_o), EW'(q_valid.size() < DEPTH));
      chk("sel_ready", EW'(sel_ready_o),
          EW'((q_valid.size() > 0) && (!m_rd_valid || rd_ready_i)));
      chk("occupancy", EW'(occupancy_o), EW'(q_valid.size()));
      chk("rd_valid", EW'(rd_valid_o), EW'(m_rd_valid));
      chk("wr_err", EW'(wr_err_o), EW'(m_err));
      if (m_rd_valid) begin
         chk("rd_hit", EW'(rd_hit_o), EW'(m_hit));
         chk("rd_literals", rd_literals_o, m_lits);
      end
   endtask

   // One clock cycle: compare at the falling edge, then advance the model.
   task automatic tick();
      logic wf, sf;
      logic [NSAT-1:0]    bv;
      logic [NSAT*EW-1:0] bd;
      int si, wi;
      @(negedge clk);
      check_all();
      wf = wr_valid_i && (q_valid.size() < DEPTH);
      sf = sel_valid_i && (q_valid.size() > 0) && (!m_rd_valid || rd_ready_i);
      @(posedge clk);
      m_err = 1'b0;
      if (flush_i) begin
         q_valid.delete();
         q_data.delete();
         open_valid = '0;
         m_rd_valid = 1'b0;
         m_hit      = 1'b0;
         m_lits     = '0;
      end else begin
         if (sf) begin
            bv = q_valid.pop_front();
            bd = q_data.pop_front();
            si = int'(sel_index_i);
            m_rd_valid = 1'b1;
            if (si < NSAT && bv[si]) begin
               m_hit  = 1'b1;
               m_lits = bd[si*EW +: EW];
            end else begin
               m_hit  = 1'b0;
               m_lits = '0;
            end
         end else if (rd_ready_i) begin
            m_rd_valid = 1'b0;
         end
         if (wf) begin
            wi = int'(wr_index_i);
            if (wi >= NSAT) begin
               m_err = 1'b1;
            end else begin
               open_valid[wi]        = 1'b1;
               open_data[wi*EW +: EW] = wr_literals_i;
            end
            if (wr_last_i) begin
               q_valid.push_back(open_valid);
               q_data.push_back(open_data);
               open_valid = '0;
            end
         end
      end
      #1;
   endtask

   task automatic idle();
      flush_i       = 1'b0;
      wr_valid_i    = 1'b0;
      wr_index_i    = '0;
      wr_last_i     = 1'b0;
      wr_literals_i = '0;
      sel_valid_i   = 1'b0;
      sel_index_i   = '0;
      rd_ready_i    = 1'b1;
   endtask

   task automatic do_write(input int idx, input logic [EW-1:0] data, input logic last);
      wr_valid_i    = 1'b1;
      wr_index_i    = IW'(idx);
      wr_literals_i = data;
      wr_last_i     = last;
      $display("write idx=%0d last=%0d data=%0h", idx, last, data[7:0]);
      tick();
      wr_valid_i = 1'b0;
      wr_last_i  = 1'b0;
   endtask

   task automatic do_sel(input int idx);
      sel_valid_i = 1'b1;
      sel_index_i = IW'(idx);
      $display("select idx=%0d", idx);
      tick();
      sel_valid_i = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_wr_ready"}, EW'(wr_ready_o), EW'(1));
      chk({tag, "_sel_ready"}, EW'(sel_ready_o), EW'(0));
      chk({tag, "_rd_valid"}, EW'(rd_valid_o), EW'(0));
      chk({tag, "_rd_hit"}, EW'(rd_hit_o), EW'(0));
      chk({tag, "_rd_literals"}, rd_literals_o, '0);
      chk({tag, "_wr_err"}, EW'(wr_err_o), EW'(0));
      chk({tag, "_occupancy"}, EW'(occupancy_o), EW'(0));
   endtask

   initial begin
      idle();
      model_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_reset_values("rst");

      // Basic write then select.
      do_write(0, pat(8'h11), 1'b0);
      do_write(1, pat(8'hA5), 1'b1);
      chk("t1_occ", EW'(occupancy_o), EW'(1));
      do_sel(1);
      chk("t1_rd_valid", EW'(rd_valid_o), EW'(1));
      chk("t1_rd_hit", EW'(rd_hit_o), EW'(1));
      chk("t1_rd_literals", rd_literals_o, pat(8'hA5));

      // Fill both banks, refused third write, one select frees a bank.
      do_write(2, pat(8'h3C), 1'b1);
      do_write(0, pat(8'h5A), 1'b1);
      chk("t2_full_wr_ready", EW'(wr_ready_o), EW'(0));
      chk("t2_full_occ", EW'(occupancy_o), EW'(2));
      do_write(1, pat(8'hEE), 1'b1);
      chk("t2_refused_occ", EW'(occupancy_o), EW'(2));
      do_sel(2);
      chk("t2_hit_x", EW'(rd_hit_o), EW'(1));
      chk("t2_lits_x", rd_literals_o, pat(8'h3C));
      chk("t2_wr_ready_after", EW'(wr_ready_o), EW'(1));
      chk("t2_occ_after", EW'(occupancy_o), EW'(1));
      do_sel(2);
      chk("t2_miss_hit", EW'(rd_hit_o), EW'(0));
      chk("t2_miss_lits", rd_literals_o, '0);

      // Out-of-range write index.
      do_write(3, pat(8'h77), 1'b0);
      chk("t3_err_pulse", EW'(wr_err_o), EW'(1));
      tick();
      chk("t3_err_drop", EW'(wr_err_o), EW'(0));
      do_write(0, pat(8'h42), 1'b1);
      do_sel(0);
      chk("t3_hit", EW'(rd_hit_o), EW'(1));
      chk("t3_lits", rd_literals_o, pat(8'h42));

      // Consumer stall then back-to-back result.
      do_write(1, pat(8'hC3), 1'b1);
      do_write(2, pat(8'h96), 1'b1);
      rd_ready_i = 1'b0;
      do_sel(1);
      sel_valid_i = 1'b1;
      sel_index_i = IW'(2);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t4_stall_sel_ready", EW'(sel_ready_o), EW'(0));
         chk("t4_stall_valid", EW'(rd_valid_o), EW'(1));
         chk("t4_stall_lits", rd_literals_o, pat(8'hC3));
      end
      rd_ready_i = 1'b1;
      tick();
      sel_valid_i = 1'b0;
      chk("t4_b2b_valid", EW'(rd_valid_o), EW'(1));
      chk("t4_b2b_hit", EW'(rd_hit_o), EW'(1));
      chk("t4_b2b_lits", rd_literals_o, pat(8'h96));

      // Flush collides with a closing write and a select.
      do_write(0, pat(8'h21), 1'b1);
      do_write(0, pat(8'h22), 1'b0);
      wr_valid_i    = 1'b1;
      wr_index_i    = IW'(1);
      wr_last_i     = 1'b1;
      wr_literals_i = pat(8'h23);
      sel_valid_i   = 1'b1;
      sel_index_i   = IW'(0);
      flush_i       = 1'b1;
      $display("flush with write idx=1 last=1 and select idx=0");
      tick();
      idle();
      chk("t5_occ", EW'(occupancy_o), EW'(0));
      chk("t5_rd_valid", EW'(rd_valid_o), EW'(0));
      chk("t5_sel_ready", EW'(sel_ready_o), EW'(0));
      for (int k = 0; k < DEPTH; k++) begin
         do_write(2, pat(8'h99), 1'b1);
         do_sel(0);
         chk("t5_flushed_hit", EW'(rd_hit_o), EW'(0));
         chk("t5_flushed_lits", rd_literals_o, '0);
      end

      // Asynchronous reset between edges while a write is pending.
      do_write(0, pat(8'h55), 1'b1);
      chk("t6_occ_before", EW'(occupancy_o), EW'(1));
      wr_valid_i    = 1'b1;
      wr_index_i    = IW'(1);
      wr_literals_i = pat(8'h66);
      #2;
      reset = 1'b1;
      $display("async reset asserted mid-cycle");
      #1;
      check_reset_values("arst");
      model_reset();
      idle();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_occ_after", EW'(occupancy_o), EW'(0));
      chk("t6_sel_ready_after", EW'(sel_ready_o), EW'(0));
      do_write(2, pat(8'h5F), 1'b1);
      do_sel(2);
      chk("t6_post_hit", EW'(rd_hit_o), EW'(1));
      chk("t6_post_lits", rd_literals_o, pat(8'h5F));
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/temporal_buffer_queue.md
# temporal_buffer_queue

Multi-epoch successor to the per-flip temporal buffer array: stores the clause-table literal sets written for each of the NSAT candidate flips of one try, for up to DEPTH tries in flight. Each try is one "bank". The writer fills the next try's bank while the heuristic selector drains the oldest one. It sits between the clause-table fetch stage and the flip-commit stage. It adds valid/ready handshakes, per-entry hit tracking, flush, and occupancy reporting.

## Interface
- NSAT, 3: candidate flips per try; entries per bank.
- LAW, 11: literal address width; a literal is LAW+1 bits.
- MCPV, 20: max clauses per variable; channels per entry.
- DEPTH, 2: banks (tries in flight), ≥1, any integer.
- Derived: EW = (NSAT-1)·MCPV·(LAW+1), the entry width. Channel c occupies bits [c·(NSAT-1)·(LAW+1) +: (NSAT-1)·(LAW+1)].
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush_i  in  1  synchronous clear of all banks and the output register.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  a bank is open for writing.
- wr_index_i  in  $clog2(NSAT)  candidate flip index.
- wr_last_i  in  1  closes the current bank with this write.
- wr_literals_i  in  EW  literals for this flip.
- wr_err_o  out  1  one-cycle pulse: an accepted write had index ≥ NSAT.
- sel_valid_i  in  1  selector has chosen a flip for the oldest closed bank.
- sel_ready_o  out  1  select can be accepted.
- sel_index_i  in  $clog2(NSAT)  selected flip.
- rd_valid_o  out  1  output register holds a result.
- rd_ready_i  in  1  consumer takes the result.
- rd_hit_o  out  1  the selected entry was written in that bank.
- rd_literals_o  out  EW  literals of the selected entry; zero on a miss.
- occupancy_o  out  $clog2(DEPTH+1)  number of closed, unread banks.

## Operation
- State: DEPTH banks × NSAT entries of EW bits plus a valid bit each; write pointer wptr and read pointer rptr (mod DEPTH, wrap DEPTH-1→0); closed count cnt; output register.
- wr_ready_o = (cnt < DEPTH).
- Write fires on wr_valid_i & wr_ready_o:
  - Stores the entry into bank wptr at wr_index_i and sets its valid bit.
  - A repeat write to the same index in an open bank overwrites the entry.
  - If wr_index_i ≥ NSAT: no store, wr_err_o pulses; wr_last_i is still honoured.
  - If wr_last_i: wptr advances and cnt increments.
- sel_ready_o = (cnt > 0) & (!rd_valid_o | rd_ready_i).
- Select fires on sel_valid_i & sel_ready_o:
  - Output register loads the entry from bank rptr at sel_index_i (rd_hit_o = its valid bit).
  - If sel_index_i ≥ NSAT, or the entry is invalid: rd_hit_o=0 and rd_literals_o=0.
  - All valid bits of bank rptr clear, rptr advances, and cnt decrements.
- Write-close and select-free in the same cycle: cnt is unchanged and both pointers advance.
- rd_valid_o clears on rd_ready_i unless a new select fires in the same cycle (back-to-back allowed).
- flush_i takes priority over any write or select in the same cycle:
  - Clears all valid bits, wptr, rptr, cnt and rd_valid_o.
  - wr_err_o is 0 that cycle.
- An open, partially written bank survives until it is closed or flushed; it is never readable before close.

## Timing
- Reset values: wr_ready_o=1 (0 only if DEPTH=0, which is not allowed); sel_ready_o=0; rd_valid_o=0; rd_hit_o=0; rd_literals_o=0; wr_err_o=0; occupancy_o=0.
- Write-to-close: a bank closed in cycle t is selectable in cycle t+1.
- Select latency: 1 cycle. A select in cycle t gives rd_* valid in cycle t+1.
- Throughput: one select per cycle while rd_ready_i=1; one write per cycle while a bank is free.
- wr_ready_o, sel_ready_o and occupancy_o are combinational from registered state only. They do not depend on same-cycle valid inputs.
- Full: cnt=DEPTH holds wr_ready_o=0. A select that fires raises wr_ready_o in the next cycle.

## Structure
- Package temporal_buffer_pkg:
  - Derived width functions: EW, index width, occupancy width.
  - The literal type: LAW+1 bits, MSB = polarity.
  - The channel-slice offset function shared with the clause-table fetch stage.
- Sub-module tbq_bank: one bank of NSAT entries with valid bits, a write port, a combinational read-with-hit port, and a clear input. temporal_buffer_queue instantiates DEPTH of them and holds the pointers, count, handshake and output register.

## Test plan
- After reset, write indices 0,1 (NSAT=3), the last on index 1 → occupancy_o=1. Select index 1 → next cycle rd_valid_o=1, rd_hit_o=1, rd_literals_o equals the written pattern 0xA5-repeat.
- DEPTH=2: close two banks without selecting → wr_ready_o=0 and the third write is not accepted. One select → wr_ready_o=1 the next cycle and occupancy_o=1.
- Select index 2, never written in the bank → rd_hit_o=0 and rd_literals_o=0. Write index 3 → wr_err_o pulses once and no entry changes.
- Hold rd_ready_i=0 with rd_valid_o=1 → sel_ready_o=0 and the output is stable for 5 cycles. Raise rd_ready_i with sel_valid_i=1 → a back-to-back result on the next cycle.
- Assert flush_i in the same cycle as a closing write and a select → next cycle occupancy_o=0, rd_valid_o=0 and all banks read as misses.
- Assert reset asynchronously mid-write, between edges → outputs are at their reset values immediately, and a previously closed bank is gone.
